// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - registered two-requester arbiter for the shared data-memory port
//
// Purpose:
//   Shares one valid/ready data-memory port between the core MEM stage and the
//   IO loader. The winner's command is latched and held on the memory port until
//   mem_ready or the watchdog expires. Completion is then reported with a
//   one-cycle done pulse that carries the read data.
//
// Optional feature:
//   DMEM_ARB_ROUND_ROBIN_EN - alternate winners on simultaneous requests.
//   When it is undefined, the core has fixed priority over IO.
//
// Ports:
//   clk, rstn                     clock, asynchronous active-low reset
//   core_read/write/addr/wdata    core request (held until core_done)
//   core_rdata, core_done         core completion (rdata valid with done)
//   io_read/write/addr/wdata      IO loader request
//   io_rdata, io_done             IO completion
//   mem_valid/rw/addr/wdata       latched command to memory
//   mem_rdata, mem_ready          memory response
//   timeout_err                   sticky watchdog flag
//   grant_io                      IO owns the port (debug)

module dmem_port_arbiter #(
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter int                TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_W-1:0] TIMEOUT_DATA   = 32'hDEADBEEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              core_read,
    input  logic              core_write,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_done,
    input  logic              io_read,
    input  logic              io_write,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [DATA_W-1:0] io_wdata,
    output logic [DATA_W-1:0] io_rdata,
    output logic              io_done,
    output logic              mem_valid,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              timeout_err,
    output logic              grant_io
);

    // The counter only has to reach TIMEOUT_CYCLES-1, so clog2 bits are enough.
    localparam int              CNT_W     = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BUSY_CORE,
        S_BUSY_IO,
        S_DONE_CORE,
        S_DONE_IO
    } state_t;

    state_t            state_q, state_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]  wdog_q, wdog_d;
    logic              err_q, err_d;
    logic              core_req, io_req, pick_io;

    assign core_req = core_read | core_write;
    assign io_req   = io_read | io_write;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    // Tracks the winner of the last contested arbitration only. Uncontested
    // grants leave it alone. The reset value 0 means "IO won last", so the
    // core takes the first tie.
    logic last_tie_core_q, last_tie_core_d;

    assign pick_io = io_req & (~core_req | last_tie_core_q);

    always_comb begin
        last_tie_core_d = last_tie_core_q;
        if (state_q == S_IDLE && core_req && io_req) begin
            last_tie_core_d = ~pick_io;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_tie_core_q <= 1'b0;
        end else begin
            last_tie_core_q <= last_tie_core_d;
        end
    end
`else
    assign pick_io = io_req & ~core_req;
`endif

    always_comb begin
        state_d = state_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        wdog_d  = wdog_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (core_req || io_req) begin
                    // A write wins over a read when both are asserted.
                    rw_d    = pick_io ? io_write : core_write;
                    addr_d  = pick_io ? io_addr  : core_addr;
                    wdata_d = pick_io ? io_wdata : core_wdata;
                    wdog_d  = '0;
                    state_d = pick_io ? S_BUSY_IO : S_BUSY_CORE;
                end
            end
            S_BUSY_CORE, S_BUSY_IO: begin
                // If mem_ready arrives on the last watchdog cycle, it still wins.
                if (mem_ready) begin
                    rdata_d = rw_q ? '0 : mem_rdata;
                    state_d = (state_q == S_BUSY_IO) ? S_DONE_IO : S_DONE_CORE;
                end else if (wdog_q == WDOG_LAST) begin
                    err_d   = 1'b1;
                    rdata_d = TIMEOUT_DATA;
                    state_d = (state_q == S_BUSY_IO) ? S_DONE_IO : S_DONE_CORE;
                end else begin
                    wdog_d = wdog_q + CNT_W'(1);
                end
            end
            S_DONE_CORE, S_DONE_IO: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            wdog_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            wdog_q  <= wdog_d;
            err_q   <= err_d;
        end
    end

    assign mem_valid   = (state_q == S_BUSY_CORE) || (state_q == S_BUSY_IO);
    assign mem_rw      = rw_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign core_done   = (state_q == S_DONE_CORE);
    assign io_done     = (state_q == S_DONE_IO);
    assign core_rdata  = core_done ? rdata_q : '0;
    assign io_rdata    = io_done ? rdata_q : '0;
    assign grant_io    = (state_q == S_BUSY_IO) || (state_q == S_DONE_IO);
    assign timeout_err = err_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - self-checking bench for dmem_port_arbiter

module tb_dmem_port_arbiter;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rstn;
    logic        core_read, core_write, io_read, io_write;
    logic [31:0] core_addr, core_wdata, io_addr, io_wdata;
    logic [31:0] core_rdata, io_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        core_done, io_done, mem_valid, mem_rw, mem_ready;
    logic        timeout_err, grant_io;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(T), .TIMEOUT_DATA(32'hDEADBEEF)) dut (
        .clk(clk), .rstn(rstn),
        .core_read(core_read), .core_write(core_write), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_rdata(core_rdata), .core_done(core_done),
        .io_read(io_read), .io_write(io_write), .io_addr(io_addr),
        .io_wdata(io_wdata), .io_rdata(io_rdata), .io_done(io_done),
        .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .timeout_err(timeout_err), .grant_io(grant_io)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: phase 0 idle, 1 waiting on memory, 2 reporting.
    int          m_phase, m_own, m_wait, m_lat, lat_next;
    bit          m_rw, m_err, m_last_tie_io, rnd;
    logic [31:0] m_addr, m_wdata, m_data, fix_rdata;

    task automatic model_reset();
        m_phase = 0; m_own = 0; m_wait = 0; m_lat = 0;
        m_rw = 0; m_err = 0; m_last_tie_io = 1;
        m_addr = '0; m_wdata = '0; m_data = '0;
    endtask

    task automatic model_step();
        bit cr, ir, io_wins;
        cr = core_read | core_write;
        ir = io_read | io_write;
        case (m_phase)
            0: if (cr || ir) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                if (cr && ir) begin
                    io_wins = !m_last_tie_io;
                    m_last_tie_io = io_wins;
                end else begin
                    io_wins = ir;
                end
`else
                io_wins = ir && !cr;
`endif
                m_own   = io_wins ? 1 : 0;
                m_rw    = io_wins ? io_write : core_write;
                m_addr  = io_wins ? io_addr : core_addr;
                m_wdata = io_wins ? io_wdata : core_wdata;
                m_wait  = 0;
                m_lat   = (lat_next < 0) ? int'($urandom_range(0, T + 2)) : lat_next;
                m_phase = 1;
            end
            1: begin
                if (mem_ready) begin
                    m_data = m_rw ? 32'h0 : mem_rdata;
                    m_phase = 2;
                end else if (m_wait == T - 1) begin
                    m_err = 1;
                    m_data = 32'hDEADBEEF;
                    m_phase = 2;
                end else begin
                    m_wait++;
                end
            end
            default: m_phase = 0;
        endcase
    endtask

    task automatic check();
        chk("mem_valid", mem_valid, m_phase == 1);
        if (m_phase == 1) begin
            chk("mem_rw", mem_rw, m_rw);
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_wdata", mem_wdata, m_wdata);
        end
        chk("core_done", core_done, m_phase == 2 && m_own == 0);
        chk("core_rdata", core_rdata, (m_phase == 2 && m_own == 0) ? m_data : 32'h0);
        chk("io_done", io_done, m_phase == 2 && m_own == 1);
        chk("io_rdata", io_rdata, (m_phase == 2 && m_own == 1) ? m_data : 32'h0);
        chk("timeout_err", timeout_err, m_err);
        chk("grant_io", grant_io, m_phase != 0 && m_own == 1);
    endtask

    // Inputs for the coming edge are already set; the memory responder answers
    // from the model's current state, then model and DUT advance together.
    task automatic cycle();
        mem_ready = (m_phase == 1) && (m_wait == m_lat);
        mem_rdata = rnd ? $urandom : fix_rdata;
        model_step();
        @(negedge clk);
        check();
    endtask

    task automatic do_txn(input bit is_io, input int lat, output int nvalid,
                          output logic [31:0] rd, output int nother, output bit got);
        lat_next = lat; nvalid = 0; nother = 0; got = 0; rd = '0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (mem_valid) nvalid++;
            if (is_io ? core_done : io_done) nother++;
            if (is_io ? io_done : core_done) begin
                rd = is_io ? io_rdata : core_rdata;
                got = 1;
                break;
            end
        end
        if (is_io) begin io_read = 0; io_write = 0; end
        else begin core_read = 0; core_write = 0; end
        cycle();
    endtask

    task automatic pair(output int first, output int second,
                        output logic [31:0] rdc, output logic [31:0] rdi);
        int k;
        core_write = 1; core_addr = 32'h40; core_wdata = 32'hAAAA5555;
        io_read = 1; io_addr = 32'h8000;
        lat_next = 0; k = 0; first = -1; second = -1; rdc = 'x; rdi = 'x;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (core_done) begin
                rdc = core_rdata; core_write = 0;
                if (k == 0) first = 0; else second = 0;
                k++;
            end
            if (io_done) begin
                rdi = io_rdata; io_read = 0;
                if (k == 0) first = 1; else second = 1;
                k++;
            end
            if (k == 2) break;
        end
        cycle();
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int n, no, f, s, nd, exp_f;
        bit got;
        logic [31:0] rd, rdc, rdi;

        rstn = 0; core_read = 0; core_write = 0; io_read = 0; io_write = 0;
        core_addr = 0; core_wdata = 0; io_addr = 0; io_wdata = 0;
        mem_ready = 0; mem_rdata = 0;
        rnd = 0; fix_rdata = 32'h0BADF00D; lat_next = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_core_rdata", core_rdata, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_grant_io", grant_io, 0);
        check();
        rstn = 1;

        // Core read, memory answers on the third valid cycle.
        core_read = 1; core_addr = 32'h10; fix_rdata = 32'h12345678;
        do_txn(0, 2, n, rd, no, got);
        chk("t1_valid_cycles", n, 3);
        chk("t1_rdata", rd, 32'h12345678);
        chk("t1_done_seen", got, 1);
        chk("t1_io_done_count", no, 0);

        // Simultaneous requests, twice.
        fix_rdata = 32'h0BADF00D;
        pair(f, s, rdc, rdi);
        chk("t2a_first", f, 0);
        chk("t2a_second", s, 1);
        chk("t2a_core_write_rdata", rdc, 32'h0);
        chk("t2a_io_rdata", rdi, 32'h0BADF00D);
        pair(f, s, rdc, rdi);
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        exp_f = 1;
`else
        exp_f = 0;
`endif
        chk("t2b_first", f, exp_f);
        chk("t2b_second", s, 1 - exp_f);

        // IO write with a silent memory runs into the watchdog.
        io_write = 1; io_addr = 32'h100; io_wdata = 32'h5;
        do_txn(1, 99, n, rd, no, got);
        chk("t3_valid_cycles", n, T);
        chk("t3_rdata", rd, 32'hDEADBEEF);
        chk("t3_done_seen", got, 1);
        chk("t3_err", timeout_err, 1);
        repeat (4) cycle();
        chk("t3_err_sticky", timeout_err, 1);

        // Core drops its request right after the grant.
        core_read = 1; core_addr = 32'h200; lat_next = 3;
        cycle();
        core_read = 0; core_addr = 32'hFFFF0000;
        nd = 0; n = 1;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (mem_valid) begin
                n++;
                chk("t4_mem_addr", mem_addr, 32'h200);
            end
            if (core_done) nd++;
        end
        chk("t4_valid_cycles", n, 4);
        chk("t4_done_count", nd, 1);

        // Asynchronous reset while IO is waiting on memory.
        io_read = 1; io_addr = 32'h300; lat_next = 99;
        repeat (3) cycle();
        chk("t5_pre_valid", mem_valid, 1);
        #2 rstn = 0;
        #1;
        chk("t5_rst_mem_valid", mem_valid, 0);
        chk("t5_rst_io_done", io_done, 0);
        chk("t5_rst_core_done", core_done, 0);
        chk("t5_rst_timeout_err", timeout_err, 0);
        chk("t5_rst_grant_io", grant_io, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rstn = 1;
        do_txn(1, 1, n, rd, no, got);
        chk("t5_valid_cycles", n, 2);
        chk("t5_rdata", rd, 32'h0BADF00D);
        chk("t5_done_seen", got, 1);

        // Randomized traffic against the model.
        rnd = 1; lat_next = -1;
        for (int i = 0; i < 1500; i++) begin
            core_read  = ($urandom_range(0, 3) == 0);
            core_write = ($urandom_range(0, 3) == 0);
            io_read    = ($urandom_range(0, 3) == 0);
            io_write   = ($urandom_range(0, 3) == 0);
            core_addr  = $urandom; core_wdata = $urandom;
            io_addr    = $urandom; io_wdata   = $urandom;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port (BRAM/DRAM front end, valid/ready handshake) between two requesters: core MEM stage and IO loader.
- Replaces the static core_start/core_end mux with a registered, handshaked arbiter.
- Latches the command, holds the grant until the memory completes, and returns read data with a one-cycle done pulse.
- Includes a timeout watchdog for stalled memory.

Parameters:
- ADDR_W, 32, address width of requesters and memory port.
- DATA_W, 32, data width.
- TIMEOUT_CYCLES, 1024, max cycles mem_valid may wait for mem_ready before abort (>=2).
- TIMEOUT_DATA, 32'hDEADBEEF, read data returned on timeout.

Ports:
- clk  in  1  single clock.
- rstn  in  1  asynchronous active-low reset.
- core_read  in  1  core read request; held until core_done.
- core_write  in  1  core write request; held until core_done.
- core_addr  in  ADDR_W  core byte address.
- core_wdata  in  DATA_W  core write data.
- core_rdata  out  DATA_W  read data to core; valid while core_done=1.
- core_done  out  1  one-cycle completion pulse to core.
- io_read  in  1  IO read request.
- io_write  in  1  IO write request.
- io_addr  in  ADDR_W  IO byte address.
- io_wdata  in  DATA_W  IO write data.
- io_rdata  out  DATA_W  read data to IO; valid while io_done=1.
- io_done  out  1  one-cycle completion pulse to IO.
- mem_valid  out  1  command valid to memory.
- mem_rw  out  1  1=write, 0=read.
- mem_addr  out  ADDR_W  latched address.
- mem_wdata  out  DATA_W  latched write data.
- mem_rdata  in  DATA_W  memory read data; valid when mem_ready=1.
- mem_ready  in  1  memory completion; one cycle.
- timeout_err  out  1  sticky; set on any timeout.
- grant_io  out  1  1 while IO owns the port (debug).

Behaviour:
- Reset (async, rstn=0): state IDLE; all outputs 0, including the rdata registers, timeout_err, grant_io and the round-robin pointer. Reset mid-transaction aborts it and issues no done pulse.
- A requester's request = read|write. If both read and write are high, write wins.
- States:
  - IDLE: arbitrate. Winner's addr, wdata and rw are latched at the clock edge. Next state BUSY_CORE or BUSY_IO. No request: stay in IDLE.
  - BUSY_x: mem_valid=1; mem_addr, mem_wdata and mem_rw come from the latch and stay stable. Watchdog counter increments each cycle.
    - mem_ready=1: capture mem_rdata (reads only; writes return 0), go to DONE_x.
    - Counter reaches TIMEOUT_CYCLES-1 with no mem_ready: set timeout_err, load TIMEOUT_DATA, go to DONE_x. mem_ready on that same cycle wins over the timeout.
  - DONE_x: x_done=1 and x_rdata=captured value for exactly one cycle; mem_valid=0; next state IDLE. The other requester's rdata stays 0.
- Latency: request high at edge t → mem_valid from t+1. mem_ready at edge t+k → done at t+k+1. Next grant no earlier than t+k+2.
- Requests dropped while BUSY do not cancel the transaction; done still pulses.
- A requester must not be re-granted in the cycle after its own done. IDLE samples requests after the DONE cycle, so a held-over request is seen as new.
- Arbitration without the feature: fixed priority, core over IO.
- grant_io=1 in BUSY_IO and DONE_IO.
- Watchdog clears on entering BUSY and is width-safe for TIMEOUT_CYCLES up to 2^16.
- timeout_err clears only on reset.

Optional Feature:
- Macro DMEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - 1-bit last-winner pointer, reset to IO so core wins the first tie.
  - On simultaneous requests, the requester that did not win last is granted.
  - A single requester is always granted.
- Undefined: fixed core>IO priority and no pointer register.

Test Plan:
1. Core read 0x0000_0010, memory returns 0x1234_5678 with mem_ready 3 cycles after mem_valid → mem_valid high 3 cycles; core_done pulses 1 cycle with core_rdata=0x1234_5678; io_done stays 0.
2. Core and IO both request at edge 0 (core write 0x40/0xAAAA_5555, IO read 0x8000), mem_ready 1 cycle later each → without macro, core first, then IO. With macro, a second simultaneous pair alternates: IO then core.
3. IO write with mem_ready never asserted, TIMEOUT_CYCLES=8 → mem_valid high exactly 8 cycles; io_done pulse with io_rdata=0xDEADBEEF; timeout_err=1 and stays set.
4. Core drops core_read 1 cycle after grant → mem_addr stays the latched value; core_done still pulses once on mem_ready.
5. rstn low mid-BUSY (asynchronous, between edges) → mem_valid, done outputs and timeout_err go 0 immediately; after release, a new IO read is granted normally.
